bp_update_gen: RTL and testbench
================================

// Module: bp_update_gen
// PURPOSE
// Commit-side producer of branch-direction updates for the branch predictor.
// - Collects committed conditional-branch outcomes from the ROB commit ports and buffers them in order.
// - Emits at most one update (fetchID, fetchOffs, taken) per cycle.
// - Output rate is credit-limited against the predictor's 4-entry update FIFO, which has no ready signal.
// - Also publishes the committed fetchID and the oldest still-pending fetchID, so fetch never overwrites PC/BP-file entries that are still needed.
// PARAMETERS
// NUM_COM      2   commit ports per cycle; port 0 is oldest
// DEPTH        8   internal update buffer entries (power of 2)
// CREDITS      4   predictor update-FIFO depth = initial credit count
// FETCH_ID_W   5   fetchID width
// FETCH_OFF_W  3   fetch-offset width
// PORTS
// clk                 in   1                       clock
// rst                 in   1                       synchronous reset, active-low
// IN_comValid         in   NUM_COM                 commit slot valid
// IN_comIsCondBr      in   NUM_COM                 slot is a conditional branch (jumps/returns are not sent)
// IN_comTaken         in   NUM_COM                 resolved direction
// IN_comFetchID       in   NUM_COM*FETCH_ID_W      fetch bundle ID
// IN_comFetchOffs     in   NUM_COM*FETCH_OFF_W     offset within the bundle
// OUT_stall           out  1                       commit must hold all slots this cycle
// OUT_bpUpdValid      out  1                       update valid, 1-cycle pulse
// OUT_bpUpdFetchID    out  FETCH_ID_W              update fetchID
// OUT_bpUpdFetchOffs  out  FETCH_OFF_W             update offset
// OUT_bpUpdTaken      out  1                       update direction
// IN_predDeq          in   1                       predictor dequeued one update; returns one credit
// OUT_comFetchID      out  FETCH_ID_W              fetchID of the youngest committed slot (any type)
// OUT_pendValid       out  1                       an update is buffered or in output register
// OUT_pendFetchID     out  FETCH_ID_W              oldest pending fetchID (output register first, else buffer head)
// OUT_overflow        out  1                       sticky error: an enqueue was dropped
// BEHAVIOUR
// - Reset (rst==0 at posedge):
//   - rd/wr pointers = 0, count = 0, credits = CREDITS.
//   - OUT_bpUpdValid = 0; OUT_comFetchID = 0; OUT_overflow = 0.
//   - Data outputs are don't-care.
//   - Reset mid-operation discards all buffered updates and any credits in flight.
// - Enqueue: each cycle, slots with Valid && IsCondBr are written in port order (0 first) at wr ptr.
//   - wr ptr advances by the number of entries written, modulo DEPTH (natural wrap).
//   - count width is clog2(DEPTH)+1.
// - Stall: OUT_stall = (DEPTH - count) < NUM_COM.
//   - Combinational from the registered count only; this cycle's pop is not credited.
//   - Commit presents nothing while OUT_stall=1.
//   - If it does anyway, entries that do not fit are dropped, OUT_overflow sets (sticky until reset), and a sim assertion fires.
// - Pop: when count>0 && credits>0, the head is loaded into the output registers, OUT_bpUpdValid=1 next cycle, rd ptr++, credits--.
//   - Otherwise OUT_bpUpdValid=0 next cycle.
//   - Enqueue into an empty buffer at cycle N gives a pop at N+1 and output valid at N+2 (no bypass).
//   - Same-cycle enqueue and pop are allowed: count += written - popped.
// - Credits: counter 0..CREDITS.
//   - IN_predDeq alone: +1. Pop alone: -1. Both in the same cycle: unchanged.
//   - IN_predDeq when credits==CREDITS without a pop: saturate and assert.
// - OUT_comFetchID: registered fetchID of the highest-index valid commit slot of the cycle; holds when no slot is valid.
// - Pending: OUT_pendValid = OUT_bpUpdValid || count>0.
//   - OUT_pendFetchID = output register fetchID when OUT_bpUpdValid, else buffer head fetchID.
// - Order: updates leave in exact commit order; none are reordered or merged.
// TESTING
// - Reset:
//   - Hold rst=0 for 2 cycles.
//   - Require: bpUpdValid=0, stall=0, pendValid=0, comFetchID=0, overflow=0, credits=4.
// - Single branch:
//   - Cycle 0: slot0 {condBr, taken=1, ID=3, offs=5}.
//   - Require: cycle 2 bpUpdValid=1, ID=3, offs=5, taken=1; cycle 3 bpUpdValid=0.
// - Credit limit:
//   - Commit 6 branches, IN_predDeq held 0.
//   - Require: exactly 4 pulses, then silence with pendValid=1.
//   - One IN_predDeq pulse -> exactly one more pulse after 2 cycles.
// - Stall/full:
//   - Credits exhausted; fill to count=7.
//   - Require: stall=1; count=6 -> stall=0.
//   - Forcing 2 slots at count=7 -> one entry dropped, overflow=1.
// - Filtering/order:
//   - Cycle 0: slot0 jump ID=1, slot1 condBr ID=2 taken=0.
//   - Require: one update with ID=2, taken=0; comFetchID=2 at cycle 1.
// - Wrap and mid-op reset:
//   - Stream 20 branches (IDs 0..19 mod 32) with predDeq echoing each pulse 1 cycle later.
//   - Require: all 20 emitted in order across pointer wrap.
//   - Then rst=0 with 3 entries buffered -> no further pulses, pendValid=0.

Source files
------------

// File: rtl/bp_update_gen.sv
// Commit-side branch-direction update generator: buffers committed conditional
// branches in order and emits them one per cycle under a credit limit.
module bp_update_gen #(
    parameter int NUM_COM     = 2,
    parameter int DEPTH       = 8,
    parameter int CREDITS     = 4,
    parameter int FETCH_ID_W  = 5,
    parameter int FETCH_OFF_W = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_COM-1:0]             IN_comValid,
    input  logic [NUM_COM-1:0]             IN_comIsCondBr,
    input  logic [NUM_COM-1:0]             IN_comTaken,
    input  logic [NUM_COM*FETCH_ID_W-1:0]  IN_comFetchID,
    input  logic [NUM_COM*FETCH_OFF_W-1:0] IN_comFetchOffs,
    output logic                           OUT_stall,
    output logic                           OUT_bpUpdValid,
    output logic [FETCH_ID_W-1:0]          OUT_bpUpdFetchID,
    output logic [FETCH_OFF_W-1:0]         OUT_bpUpdFetchOffs,
    output logic                           OUT_bpUpdTaken,
    input  logic                           IN_predDeq,
    output logic [FETCH_ID_W-1:0]          OUT_comFetchID,
    output logic                           OUT_pendValid,
    output logic [FETCH_ID_W-1:0]          OUT_pendFetchID,
    output logic                           OUT_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = $clog2(CREDITS + 1);

    logic [FETCH_ID_W-1:0]  bufID    [DEPTH];
    logic [FETCH_OFF_W-1:0] bufOffs  [DEPTH];
    logic                   bufTaken [DEPTH];

    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] count;
    logic [CRD_W-1:0] credits;

    logic [CNT_W-1:0]      nWr;
    logic [CNT_W-1:0]      space;
    logic                  dropped;
    logic [NUM_COM-1:0]    slotWr;
    logic [PTR_W-1:0]      slotIdx [NUM_COM];
    logic                  anyValid;
    logic [FETCH_ID_W-1:0] lastID;
    logic                  pop;

    // Free space is judged from the registered count only, same as the stall.
    always_comb begin
        nWr     = '0;
        dropped = 1'b0;
        slotWr  = '0;
        space   = CNT_W'(DEPTH) - count;
        for (int unsigned i = 0; i < NUM_COM; i++) begin
            slotIdx[i] = wrPtr + PTR_W'(nWr);
            if (IN_comValid[i] && IN_comIsCondBr[i]) begin
                if (nWr < space) begin
                    slotWr[i] = 1'b1;
                    nWr       = nWr + CNT_W'(1);
                end else begin
                    dropped = 1'b1;
                end
            end
        end
    end

    always_comb begin
        anyValid = 1'b0;
        lastID   = '0;
        for (int unsigned i = 0; i < NUM_COM; i++) begin
            if (IN_comValid[i]) begin
                anyValid = 1'b1;
                lastID   = IN_comFetchID[i*FETCH_ID_W +: FETCH_ID_W];
            end
        end
    end

    assign pop             = (count != '0) && (credits != '0);
    assign OUT_stall       = (CNT_W'(DEPTH) - count) < CNT_W'(NUM_COM);
    assign OUT_pendValid   = OUT_bpUpdValid || (count != '0);
    assign OUT_pendFetchID = OUT_bpUpdValid ? OUT_bpUpdFetchID : bufID[rdPtr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdPtr          <= '0;
            wrPtr          <= '0;
            count          <= '0;
            credits        <= CRD_W'(CREDITS);
            OUT_bpUpdValid <= 1'b0;
            OUT_comFetchID <= '0;
            OUT_overflow   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_COM; i++) begin
                if (slotWr[i]) begin
                    bufID[slotIdx[i]]    <= IN_comFetchID[i*FETCH_ID_W +: FETCH_ID_W];
                    bufOffs[slotIdx[i]]  <= IN_comFetchOffs[i*FETCH_OFF_W +: FETCH_OFF_W];
                    bufTaken[slotIdx[i]] <= IN_comTaken[i];
                end
            end
            wrPtr          <= wrPtr + PTR_W'(nWr);
            count          <= count + nWr - CNT_W'(pop);
            OUT_bpUpdValid <= pop;
            if (pop) begin
                OUT_bpUpdFetchID   <= bufID[rdPtr];
                OUT_bpUpdFetchOffs <= bufOffs[rdPtr];
                OUT_bpUpdTaken     <= bufTaken[rdPtr];
                rdPtr              <= rdPtr + PTR_W'(1);
            end
            // A returned credit and a pop in the same cycle cancel out.
            case ({IN_predDeq, pop})
                2'b10: if (credits != CRD_W'(CREDITS)) credits <= credits + CRD_W'(1);
                2'b01: credits <= credits - CRD_W'(1);
                default: ;
            endcase
            if (anyValid) OUT_comFetchID <= lastID;
            if (dropped)  OUT_overflow   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!dropped)
                else $warning("bp_update_gen: commit enqueue dropped, buffer full");
            assert (!(IN_predDeq && !pop && credits == CRD_W'(CREDITS)))
                else $warning("bp_update_gen: credit return beyond predictor FIFO depth");
        end
    end

endmodule

// File: tb/tb_bp_update_gen.sv
// Testbench for bp_update_gen: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_bp_update_gen;

    logic       clk;
    logic       rst;
    logic [1:0] comValid, comIsCondBr, comTaken;
    logic [9:0] comFetchID;
    logic [5:0] comFetchOffs;
    logic       predDeq;
    logic       stall, updValid, updTaken, pendValid, overflow;
    logic [4:0] updID, comFID, pendID;
    logic [2:0] updOffs;

    bp_update_gen #(
        .NUM_COM(2), .DEPTH(8), .CREDITS(4), .FETCH_ID_W(5), .FETCH_OFF_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .IN_comValid(comValid), .IN_comIsCondBr(comIsCondBr), .IN_comTaken(comTaken),
        .IN_comFetchID(comFetchID), .IN_comFetchOffs(comFetchOffs),
        .OUT_stall(stall), .OUT_bpUpdValid(updValid), .OUT_bpUpdFetchID(updID),
        .OUT_bpUpdFetchOffs(updOffs), .OUT_bpUpdTaken(updTaken), .IN_predDeq(predDeq),
        .OUT_comFetchID(comFID), .OUT_pendValid(pendValid), .OUT_pendFetchID(pendID),
        .OUT_overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int outst  = 0;
    int gotID[$];
    int gotTO[$];

    typedef struct {
        logic [1:0] v, c, t;
        logic [4:0] id0, id1;
        logic [2:0] o0, o1;
        logic       deq;
        logic       eValid;
        logic [4:0] eID;
        logic [2:0] eOffs;
        logic       eTaken;
        logic       ePend;
        logic [4:0] ePendID;
        logic [4:0] eComID;
    } vec_t;
    vec_t tbl [14];

    typedef struct { int id; int offs; int taken; } upd_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            if (updValid) begin
                outst++;
                gotID.push_back(int'(updID));
                gotTO.push_back(int'({updTaken, updOffs}));
            end
            if (predDeq && outst > 0) outst--;
        end
    endtask

    task automatic clearIn();
        comValid = '0; comIsCondBr = '0; comTaken = '0;
        comFetchID = '0; comFetchOffs = '0;
    endtask

    task automatic setSlot(input int s, input bit c, input bit t, input int id, input int offs);
        comValid[s]            = 1'b1;
        comIsCondBr[s]         = c;
        comTaken[s]            = t;
        comFetchID[s*5 +: 5]   = 5'(id);
        comFetchOffs[s*3 +: 3] = 3'(offs);
    endtask

    task automatic doReset();
        rst = 1'b0; predDeq = 1'b0; clearIn();
        tick(); tick();
        rst = 1'b1;
        outst = 0; gotID.delete(); gotTO.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        upd_t q[$];
        upd_t mOut;
        int   mCred, sz, n, sent;
        bit   mOutV, mOvf, mPop;
        int   mCom;

        // v, c, t, id0, id1, o0, o1, deq | valid, id, offs, taken | pend, pendID | comID
        tbl[0]  = '{2'b01, 2'b01, 2'b01, 5'd3, 5'd0, 3'd5, 3'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 5'd3, 5'd3};
        tbl[1]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 1'b1, 5'd3, 3'd5, 1'b1, 1'b1, 5'd3, 5'd3};
        tbl[2]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd3};
        tbl[3]  = '{2'b11, 2'b10, 2'b00, 5'd1, 5'd2, 3'd0, 3'd4, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 5'd2, 5'd2};
        tbl[4]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 1'b1, 5'd2, 3'd4, 1'b0, 1'b1, 5'd2, 5'd2};
        tbl[5]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd2};
        tbl[6]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd2};
        tbl[7]  = '{2'b11, 2'b11, 2'b01, 5'd7, 5'd8, 3'd1, 3'd2, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 5'd7, 5'd8};
        tbl[8]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 1'b1, 5'd7, 3'd1, 1'b1, 1'b1, 5'd7, 5'd8};
        tbl[9]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 1'b1, 5'd8, 3'd2, 1'b0, 1'b1, 5'd8, 5'd8};
        tbl[10] = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd8};
        tbl[11] = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd8};
        tbl[12] = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd8};
        tbl[13] = '{2'b10, 2'b00, 2'b00, 5'd0, 5'd9, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd9};

        rst = 1'b1; predDeq = 1'b0; clearIn();

        // Reset state
        doReset();
        check("rst_valid", int'(updValid), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_pend", int'(pendValid), 0);
        check("rst_comID", int'(comFID), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_credits", int'(dut.credits), 4);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            comValid = tbl[i].v; comIsCondBr = tbl[i].c; comTaken = tbl[i].t;
            comFetchID = {tbl[i].id1, tbl[i].id0};
            comFetchOffs = {tbl[i].o1, tbl[i].o0};
            predDeq = tbl[i].deq;
            tick();
            clearIn(); predDeq = 1'b0;
            check($sformatf("vec%0d_valid", i), int'(updValid), int'(tbl[i].eValid));
            if (tbl[i].eValid) begin
                check($sformatf("vec%0d_id", i), int'(updID), int'(tbl[i].eID));
                check($sformatf("vec%0d_offs", i), int'(updOffs), int'(tbl[i].eOffs));
                check($sformatf("vec%0d_taken", i), int'(updTaken), int'(tbl[i].eTaken));
            end
            check($sformatf("vec%0d_pend", i), int'(pendValid), int'(tbl[i].ePend));
            if (tbl[i].ePend) check($sformatf("vec%0d_pendID", i), int'(pendID), int'(tbl[i].ePendID));
            check($sformatf("vec%0d_comID", i), int'(comFID), int'(tbl[i].eComID));
        end

        // Credit limit: 6 branches, no credit returns
        doReset();
        for (int k = 0; k < 3; k++) begin
            setSlot(0, 1, 1, 2*k, 0); setSlot(1, 1, 0, 2*k+1, 0);
            tick(); clearIn();
        end
        for (int k = 0; k < 12; k++) tick();
        check("credit_pulses", gotID.size(), 4);
        check("credit_pend", int'(pendValid), 1);
        for (int k = 0; k < 4 && k < gotID.size(); k++) check($sformatf("credit_order%0d", k), gotID[k], k);
        predDeq = 1'b1; tick(); predDeq = 1'b0;
        check("deq_lat1_valid", int'(updValid), 0);
        tick();
        check("deq_lat2_valid", int'(updValid), 1);
        check("deq_lat2_id", int'(updID), 4);
        for (int k = 0; k < 5; k++) tick();
        check("deq_one_pulse", gotID.size(), 5);

        // Stall / full / overflow with credits exhausted (count=1 here)
        check("fill_stall_c1", int'(stall), 0);
        gotID.delete(); gotTO.delete();
        for (int k = 0; k < 3; k++) begin
            setSlot(0, 1, 0, 10+2*k, 0); setSlot(1, 1, 0, 11+2*k, 0);
            tick(); clearIn();
            check($sformatf("fill_stall_step%0d", k), int'(stall), (k == 2) ? 1 : 0);
        end
        setSlot(0, 1, 0, 20, 0); setSlot(1, 1, 0, 21, 0);
        tick(); clearIn();
        check("force_overflow", int'(overflow), 1);
        check("force_stall", int'(stall), 1);
        predDeq = 1'b1; tick(); predDeq = 1'b0; tick();
        check("count7_stall", int'(stall), 1);
        predDeq = 1'b1; tick(); predDeq = 1'b0; tick();
        check("count6_stall", int'(stall), 0);
        for (int k = 0; k < 40; k++) begin
            predDeq = (outst > 0); tick();
        end
        predDeq = 1'b0;
        check("drain_count", gotID.size(), 8);
        begin
            int expIDs[8] = '{5, 10, 11, 12, 13, 14, 15, 20};
            for (int k = 0; k < 8 && k < gotID.size(); k++)
                check($sformatf("drain_order%0d", k), gotID[k], expIDs[k]);
        end
        check("overflow_sticky", int'(overflow), 1);

        // Pointer wrap with credits echoed one cycle after each pulse
        doReset();
        sent = 0;
        for (int cyc = 0; cyc < 200 && gotID.size() < 20; cyc++) begin
            clearIn();
            predDeq = updValid;
            if (sent < 20 && !stall) begin
                setSlot(0, 1, sent % 2, sent, sent % 8);
                sent++;
            end
            tick();
        end
        clearIn(); predDeq = updValid; tick(); predDeq = 1'b0;
        check("wrap_count", gotID.size(), 20);
        for (int k = 0; k < 20 && k < gotID.size(); k++) begin
            check($sformatf("wrap_id%0d", k), gotID[k], k % 32);
            check($sformatf("wrap_to%0d", k), gotTO[k], ((k % 2) << 3) | (k % 8));
        end

        // Mid-operation reset with 3 entries buffered
        gotID.delete(); gotTO.delete();
        for (int k = 0; k < 7; k++) begin
            setSlot(0, 1, 1, k, 0); tick(); clearIn();
        end
        for (int k = 0; k < 10; k++) tick();
        check("midrst_pre_pulses", gotID.size(), 4);
        check("midrst_pre_pend", int'(pendValid), 1);
        check("midrst_pre_count", int'(dut.count), 3);
        rst = 1'b0; tick(); rst = 1'b1;
        outst = 0; gotID.delete(); gotTO.delete();
        check("midrst_pend0", int'(pendValid), 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("midrst_pend%0d", k+1), int'(pendValid), 0);
        end
        check("midrst_no_pulses", gotID.size(), 0);
        for (int k = 0; k < 2; k++) begin
            setSlot(0, 1, 0, 2*k, 0); setSlot(1, 1, 0, 2*k+1, 0); tick(); clearIn();
        end
        for (int k = 0; k < 10; k++) tick();
        check("midrst_credits_restored", gotID.size(), 4);

        // Randomized traffic against the reference model
        doReset();
        q.delete(); mCred = 4; mOutV = 0; mOvf = 0; mCom = 0;
        mOut = '{0, 0, 0};
        for (int cyc = 0; cyc < 600; cyc++) begin
            clearIn();
            predDeq = (mCred < 4) && ($urandom % 3 != 0);
            if (8 - q.size() >= 2) begin
                for (int s = 0; s < 2; s++)
                    if ($urandom % 4 != 0)
                        setSlot(s, $urandom % 3 != 0, $urandom % 2, $urandom % 32, $urandom % 8);
            end
            sz = q.size();
            mPop = (sz > 0) && (mCred > 0);
            mOutV = mPop;
            if (mPop) mOut = q.pop_front();
            if (predDeq && !mPop) mCred++;
            else if (mPop && !predDeq) mCred--;
            n = 0;
            for (int s = 0; s < 2; s++) begin
                if (comValid[s]) begin
                    mCom = int'(comFetchID[s*5 +: 5]);
                    if (comIsCondBr[s]) begin
                        if (n < 8 - sz) begin
                            q.push_back('{int'(comFetchID[s*5 +: 5]), int'(comFetchOffs[s*3 +: 3]), int'(comTaken[s])});
                            n++;
                        end else mOvf = 1;
                    end
                end
            end
            tick();
            check("rnd_valid", int'(updValid), int'(mOutV));
            if (mOutV) begin
                check("rnd_id", int'(updID), mOut.id);
                check("rnd_offs", int'(updOffs), mOut.offs);
                check("rnd_taken", int'(updTaken), mOut.taken);
            end
            check("rnd_stall", int'(stall), (8 - q.size() < 2) ? 1 : 0);
            check("rnd_pend", int'(pendValid), (mOutV || q.size() > 0) ? 1 : 0);
            if (mOutV) check("rnd_pendID", int'(pendID), mOut.id);
            else if (q.size() > 0) check("rnd_pendID", int'(pendID), q[0].id);
            check("rnd_comID", int'(comFID), mCom);
            check("rnd_overflow", int'(overflow), int'(mOvf));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
